spi_frame_rx: RTL and testbench

Receive front end for the onboarding SPI register interface. Samples the raw chip-pin SPI signals (ncs, sclk, copi) into the system clock domain and assembles 16-bit mode-0 frames. For each valid write frame it emits a single-cycle write strobe with a 7-bit address and 8-bit data. It sits between the chip input pins and the control-register bank that drives the PWM peripheral.

---
 rtl/spi_rx_pkg.sv | 13 +
 rtl/sync_edge_det.sv | 33 +++
 rtl/spi_frame_rx.sv | 107 ++++++++++
 tb/tb_spi_frame_rx.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg: shared frame geometry and FSM state type for the SPI frame receiver
package spi_rx_pkg;
    localparam int FRAME_BITS = 16;
    localparam int ADDR_W     = 7;
    localparam int DATA_W     = 8;
    localparam int CNT_SAT    = 17;
    localparam int CNT_W      = 5;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        EVAL  = 2'd2
    } state_t;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: multi-flop synchroniser for an asynchronous input with rise/fall pulse detection
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   i_d      raw asynchronous input
//   o_level  synchronised level
//   o_rise   one-cycle pulse on a synchronised rising edge
//   o_fall   one-cycle pulse on a synchronised falling edge
module sync_edge_det #(
    parameter int   DEPTH   = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [DEPTH-1:0] r_sync;
    logic             r_prev;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {DEPTH{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[DEPTH-2:0], i_d};
            r_prev <= r_sync[DEPTH-1];
        end
    end
    assign o_level = r_sync[DEPTH-1];
    assign o_rise  = o_level & ~r_prev;
    assign o_fall  = ~o_level & r_prev;
endmodule

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: SPI mode-0 receive front end assembling 16-bit frames into register write strobes
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ncs        raw SPI chip select (active low, asynchronous)
//   sclk       raw SPI clock (asynchronous)
//   copi       raw SPI serial data in (asynchronous)
//   wr_valid   one-cycle write strobe
//   wr_addr    address of the last accepted write
//   wr_data    data of the last accepted write
//   frame_err  one-cycle pulse on a malformed frame
//   err_count  saturating malformed-frame count; live only when SPI_RX_ERR_CNT_EN is defined
module spi_frame_rx
    import spi_rx_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ncs,
    input  logic              sclk,
    input  logic              copi,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              frame_err,
    output logic [7:0]        err_count
);
    logic w_ncs_rise, w_ncs_fall, w_sclk_rise, w_copi;
    state_t                r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_wr_valid, r_frame_err;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [DATA_W-1:0]     r_wr_data;

    // ncs syncs reset to 0 so a chip select already low at reset release never looks like a frame start
    sync_edge_det #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_ncs (
        .clk(clk), .rst_n(rst_n), .i_d(ncs),
        .o_level(), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
    );
    sync_edge_det #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(clk), .rst_n(rst_n), .i_d(sclk),
        .o_level(), .o_rise(w_sclk_rise), .o_fall()
    );
    sync_edge_det #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_copi (
        .clk(clk), .rst_n(rst_n), .i_d(copi),
        .o_level(w_copi), .o_rise(), .o_fall()
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_wr_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
        end else begin
            r_wr_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_shift <= '0;
                    r_cnt   <= '0;
                    if (w_ncs_fall) r_state <= SHIFT;
                end
                SHIFT: begin
                    // chip-select release takes priority over a coincident sclk edge
                    if (w_ncs_rise) begin
                        r_state <= EVAL;
                    end else if (w_sclk_rise) begin
                        r_shift <= {r_shift[FRAME_BITS-2:0], w_copi};
                        if (r_cnt != CNT_W'(CNT_SAT)) r_cnt <= r_cnt + 1'b1;
                    end
                end
                EVAL: begin
                    r_state <= IDLE;
                    if (r_cnt != CNT_W'(FRAME_BITS)) begin
                        r_frame_err <= 1'b1;
                    end else if (r_shift[FRAME_BITS-1]) begin
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= r_shift[FRAME_BITS-2:DATA_W];
                        r_wr_data  <= r_shift[DATA_W-1:0];
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign wr_valid  = r_wr_valid;
    assign frame_err = r_frame_err;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;

`ifdef SPI_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_err_cnt <= '0;
        else if (r_frame_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
    assign err_count = r_err_cnt;
`else
    assign err_count = 8'h00;
`endif
endmodule

// File: tb/tb_spi_frame_rx.sv
// tb_spi_frame_rx: directed scoreboard bench for spi_frame_rx
module tb_spi_frame_rx;
`ifdef SPI_RX_ERR_CNT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ncs = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       wr_valid, frame_err;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] err_count;

    int errors = 0;
    int checks = 0;
    int n_wv = 0;
    int n_fe = 0;
    logic [14:0] exp_q[$];

    spi_frame_rx #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .ncs(ncs), .sclk(sclk), .copi(copi),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_err(frame_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // scoreboard: every write strobe must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_valid && frame_err) chk("exclusive", 1, 0);
            if (frame_err) n_fe++;
            if (wr_valid) begin
                n_wv++;
                if (exp_q.size() == 0) chk("unexpected_wr", {17'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
                else chk("sb_wr", {17'd0, wr_addr, wr_data}, {17'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            copi = v[i];
            clks(4);
            sclk = 1'b1;
            clks(4);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [31:0] v, input int n, input int gap);
        ncs = 1'b0;
        clks(4);
        shift_bits(v, n);
        clks(4);
        ncs = 1'b1;
        clks(gap);
    endtask

    int wv0, fe0;

    initial begin
        clks(3);
        chk("rst_wr_valid", wr_valid, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_err_count", err_count, 0);
        rst_n = 1'b1;
        clks(6);

        // write 0x84A5 with latency check from ncs rise
        exp_q.push_back({7'h04, 8'hA5});
        ncs = 1'b0;
        clks(4);
        shift_bits(32'h84A5, 16);
        clks(4);
        ncs = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("lat_early", wr_valid, 0);
        @(posedge clk);
        #1 chk("lat_4", wr_valid, 1);
        chk("wr_addr_84A5", wr_addr, 7'h04);
        chk("wr_data_84A5", wr_data, 8'hA5);
        chk("err_84A5", frame_err, 0);
        clks(8);

        // read request is dropped silently
        wv0 = n_wv; fe0 = n_fe;
        frame(32'h0233, 16, 8);
        chk("read_no_wv", n_wv - wv0, 0);
        chk("read_no_fe", n_fe - fe0, 0);
        chk("read_addr_hold", wr_addr, 7'h04);
        chk("read_data_hold", wr_data, 8'hA5);

        // short and long frames
        wv0 = n_wv; fe0 = n_fe;
        frame(32'h7FFF, 15, 8);
        frame(32'hFABCD, 20, 8);
        chk("bad_fe", n_fe - fe0, 2);
        chk("bad_no_wv", n_wv - wv0, 0);
        chk("bad_addr_hold", wr_addr, 7'h04);
        chk("bad_data_hold", wr_data, 8'hA5);
        chk("bad_err_count", err_count, ERR_EN ? 2 : 0);

        // reset in mid-frame, released with ncs still low
        ncs = 1'b0;
        clks(4);
        shift_bits(32'h81, 8);
        rst_n = 1'b0;
        clks(3);
        rst_n = 1'b1;
        wv0 = n_wv; fe0 = n_fe;
        shift_bits(32'h3C, 8);
        clks(4);
        ncs = 1'b1;
        clks(8);
        chk("midrst_no_wv", n_wv - wv0, 0);
        chk("midrst_no_fe", n_fe - fe0, 0);
        chk("midrst_addr", wr_addr, 0);
        exp_q.push_back({7'h0F, 8'hFF});
        frame(32'h8FFF, 16, 8);
        chk("post_rst_addr", wr_addr, 7'h0F);
        chk("post_rst_data", wr_data, 8'hFF);

        // zero-bit frames drive the error counter to saturation
        fe0 = n_fe;
        for (int i = 0; i < 300; i++) begin
            ncs = 1'b0;
            clks(4);
            ncs = 1'b1;
            clks(4);
        end
        clks(4);
        chk("zero_fe_count", n_fe - fe0, 300);
        chk("err_sat", err_count, ERR_EN ? 255 : 0);

        // back-to-back writes with minimum chip-select gap
        wv0 = n_wv;
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back({i[6:0], 8'(8'h30 + i * 7)});
            frame({16'd0, 1'b1, i[6:0], 8'(8'h30 + i * 7)}, 16, 4);
        end
        clks(10);
        chk("b2b_count", n_wv - wv0, 10);
        chk("sb_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
